instr_dispatch: RTL and testbench

Decode/issue stage between instruction fetch and the execution units (ALU, BRU, MAU).
- Accepts one 32-bit RV32I instruction per cycle over a valid/ready handshake.
- Decodes the instruction into unit, rd, rs1, rs2 and a fully extended immediate.
- Holds it in a single decode register until there are no register hazards, then issues it to exactly one unit.
- A 32-entry pending-write scoreboard tracks RAW and WAW hazards.
- HALT drains the pipeline and then stops issuing.

---
 rtl/instr_dispatch_if.sv | 36 +++
 rtl/instr_dispatch.sv | 260 ++++++++++++++++++++++++++
 tb/tb_instr_dispatch.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_dispatch_if.sv
// Fetch, issue and writeback bundle for instr_dispatch.
// master: the dispatch stage; slave: fetch, execution units and writeback.
interface instr_dispatch_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            alu_valid;
    logic            alu_ready;
    logic            bru_valid;
    logic            bru_ready;
    logic            mau_valid;
    logic            mau_ready;
    logic [31:0]     iss_instr;
    logic [XLEN-1:0] iss_pc;
    logic [4:0]      iss_rd;
    logic [4:0]      iss_rs1;
    logic [4:0]      iss_rs2;
    logic [XLEN-1:0] iss_imm;
    logic            wb_valid;
    logic [4:0]      wb_rd;

    modport master (
        input  in_valid, in_instr, in_pc, alu_ready, bru_ready, mau_ready, wb_valid, wb_rd,
        output in_ready, alu_valid, bru_valid, mau_valid,
        output iss_instr, iss_pc, iss_rd, iss_rs1, iss_rs2, iss_imm
    );

    modport slave (
        output in_valid, in_instr, in_pc, alu_ready, bru_ready, mau_ready, wb_valid, wb_rd,
        input  in_ready, alu_valid, bru_valid, mau_valid,
        input  iss_instr, iss_pc, iss_rd, iss_rs1, iss_rs2, iss_imm
    );
endinterface

// File: rtl/instr_dispatch.sv
// RV32I decode/issue stage: one decode register, 32-entry pending-write scoreboard, HALT drain.
// Optional macro ILLEGAL_TRAP_EN: illegal words trap (TRAP state) instead of being dropped.
module instr_dispatch #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_dispatch_if.master bus,
    output logic             halted,
    output logic             illegal,
    output logic [XLEN-1:0]  illegal_pc,
    output logic [CNT_W-1:0] issue_count
);
    localparam logic [31:0] HALT_WORD = 32'h0001_0073;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {U_ALU, U_BRU, U_MAU, U_HALT, U_ILL} unit_e;
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED, S_TRAP} state_e;

    state_e           state_r, state_next_s;
    unit_e            unit_s, d_unit_r;
    logic [31:0]      instr_s, imm32_s, i_imm_s, s_imm_s, b_imm_s, u_imm_s, j_imm_s;
    logic [6:0]       opcode_s, f7_s;
    logic [2:0]       f3_s;
    logic             has_rd_s, has_rs1_s, has_rs2_s, imm_ok_s, reg_ok_s;
    logic [4:0]       rd_s, rs1_s, rs2_s;
    logic             d_valid_r, d_wr_r;
    logic [31:0]      d_instr_r;
    logic [XLEN-1:0]  d_pc_r, d_imm_r;
    logic [4:0]       d_rd_r, d_rs1_r, d_rs2_r;
    logic [31:0]      pending_r, pend_eff_s, clr_s, set_s, pending_next_s;
    logic             hazard_s, alu_v_s, bru_v_s, mau_v_s, issue_fire_s, accept_s, consume_s, trap_req_s;
    logic [CNT_W-1:0] issue_count_r;
    logic [XLEN-1:0]  illegal_pc_r;

    assign instr_s  = bus.in_instr;
    assign opcode_s = instr_s[6:0];
    assign f3_s     = instr_s[14:12];
    assign f7_s     = instr_s[31:25];
    assign i_imm_s  = {{20{instr_s[31]}}, instr_s[31:20]};
    assign s_imm_s  = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
    assign b_imm_s  = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
    assign u_imm_s  = {instr_s[31:12], 12'h000};
    assign j_imm_s  = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
    // Shift-immediates and SUB/SRA are the only encodings with non-zero funct7.
    assign imm_ok_s = (f3_s == 3'b001) ? (f7_s == 7'b0000000) :
                      (f3_s == 3'b101) ? ((f7_s == 7'b0000000) || (f7_s == 7'b0100000)) : 1'b1;
    assign reg_ok_s = (f7_s == 7'b0000000) ||
                      ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101)));

    // Decode the incoming word into unit, register-field presence and a 32-bit immediate.
    always_comb begin
        unit_s    = U_ILL;
        has_rd_s  = 1'b0;
        has_rs1_s = 1'b0;
        has_rs2_s = 1'b0;
        imm32_s   = 32'h0000_0000;
        if (instr_s == HALT_WORD) begin
            unit_s = U_HALT;
        end else begin
            case (opcode_s)
                OP_LUI, OP_AUIPC: begin
                    unit_s = U_ALU; has_rd_s = 1'b1; imm32_s = u_imm_s;
                end
                OP_JAL: begin
                    unit_s = U_BRU; has_rd_s = 1'b1; imm32_s = j_imm_s;
                end
                OP_JALR: begin
                    if (f3_s == 3'b000) begin
                        unit_s = U_BRU; has_rd_s = 1'b1; has_rs1_s = 1'b1; imm32_s = i_imm_s;
                    end else begin
                        unit_s = U_ILL;
                    end
                end
                OP_BRANCH: begin
                    if ((f3_s != 3'b010) && (f3_s != 3'b011)) begin
                        unit_s = U_BRU; has_rs1_s = 1'b1; has_rs2_s = 1'b1; imm32_s = b_imm_s;
                    end else begin
                        unit_s = U_ILL;
                    end
                end
                OP_LOAD: begin
                    if ((f3_s != 3'b011) && (f3_s != 3'b110) && (f3_s != 3'b111)) begin
                        unit_s = U_MAU; has_rd_s = 1'b1; has_rs1_s = 1'b1; imm32_s = i_imm_s;
                    end else begin
                        unit_s = U_ILL;
                    end
                end
                OP_STORE: begin
                    if (f3_s <= 3'b010) begin
                        unit_s = U_MAU; has_rs1_s = 1'b1; has_rs2_s = 1'b1; imm32_s = s_imm_s;
                    end else begin
                        unit_s = U_ILL;
                    end
                end
                OP_IMM: begin
                    if (imm_ok_s) begin
                        unit_s = U_ALU; has_rd_s = 1'b1; has_rs1_s = 1'b1; imm32_s = i_imm_s;
                    end else begin
                        unit_s = U_ILL;
                    end
                end
                OP_REG: begin
                    if (reg_ok_s) begin
                        unit_s = U_ALU; has_rd_s = 1'b1; has_rs1_s = 1'b1; has_rs2_s = 1'b1;
                    end else begin
                        unit_s = U_ILL;
                    end
                end
                default: unit_s = U_ILL;
            endcase
        end
    end

    assign rd_s  = has_rd_s  ? instr_s[11:7]  : 5'd0;
    assign rs1_s = has_rs1_s ? instr_s[19:15] : 5'd0;
    assign rs2_s = has_rs2_s ? instr_s[24:20] : 5'd0;

    // A writeback in this cycle un-blocks its register for this cycle's hazard check.
    assign clr_s      = bus.wb_valid ? (32'd1 << bus.wb_rd) : 32'd0;
    assign pend_eff_s = pending_r & ~clr_s;
    assign hazard_s   = pend_eff_s[d_rs1_r] | pend_eff_s[d_rs2_r] | pend_eff_s[d_rd_r];

    // Steer the held instruction to exactly one unit once it is hazard-free.
    always_comb begin
        alu_v_s = 1'b0;
        bru_v_s = 1'b0;
        mau_v_s = 1'b0;
        if (d_valid_r && !hazard_s) begin
            case (d_unit_r)
                U_ALU:   alu_v_s = 1'b1;
                U_BRU:   bru_v_s = 1'b1;
                U_MAU:   mau_v_s = 1'b1;
                default: alu_v_s = 1'b0;
            endcase
        end else begin
            alu_v_s = 1'b0;
        end
    end

    assign issue_fire_s = (alu_v_s & bus.alu_ready) | (bru_v_s & bus.bru_ready) | (mau_v_s & bus.mau_ready);
    assign consume_s    = d_valid_r && ((d_unit_r == U_HALT) || (d_unit_r == U_ILL));
    assign accept_s     = bus.in_valid && bus.in_ready;
    assign set_s        = (issue_fire_s && d_wr_r) ? (32'd1 << d_rd_r) : 32'd0;
    assign pending_next_s = ((pending_r & ~clr_s) | set_s) & ~32'd1;

`ifdef ILLEGAL_TRAP_EN
    assign trap_req_s = d_valid_r && (d_unit_r == U_ILL);
`else
    assign trap_req_s = 1'b0;
`endif

    // Decode register: load on accept, empty on issue or when HALT/illegal is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid_r <= 1'b0;
            d_unit_r  <= U_ALU;
            d_instr_r <= 32'h0000_0000;
            d_pc_r    <= {XLEN{1'b0}};
            d_imm_r   <= {XLEN{1'b0}};
            d_rd_r    <= 5'd0;
            d_rs1_r   <= 5'd0;
            d_rs2_r   <= 5'd0;
            d_wr_r    <= 1'b0;
        end else if (accept_s) begin
            d_valid_r <= 1'b1;
            d_unit_r  <= unit_s;
            d_instr_r <= instr_s;
            d_pc_r    <= bus.in_pc;
            d_imm_r   <= XLEN'($signed(imm32_s));
            d_rd_r    <= rd_s;
            d_rs1_r   <= rs1_s;
            d_rs2_r   <= rs2_s;
            d_wr_r    <= has_rd_s && (rd_s != 5'd0);
        end else if (issue_fire_s || consume_s) begin
            d_valid_r <= 1'b0;
        end
    end

    // Scoreboard, issue counter and trap pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r     <= 32'd0;
            issue_count_r <= {CNT_W{1'b0}};
            illegal_pc_r  <= {XLEN{1'b0}};
        end else begin
            pending_r <= pending_next_s;
            if (issue_fire_s) begin
                issue_count_r <= issue_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (trap_req_s && (state_r == S_RUN)) begin
                illegal_pc_r <= d_pc_r;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; DRAIN completes on the same edge as the last writeback.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_RUN: begin
                if (d_valid_r && (d_unit_r == U_HALT)) begin
                    state_next_s = S_DRAIN;
                end else if (trap_req_s) begin
                    state_next_s = S_TRAP;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DRAIN: begin
                if (pending_next_s == 32'd0) begin
                    state_next_s = S_HALTED;
                end else begin
                    state_next_s = S_DRAIN;
                end
            end
            S_HALTED: state_next_s = S_HALTED;
            S_TRAP:   state_next_s = S_TRAP;
            default:  state_next_s = S_RUN;
        endcase
    end

    assign bus.in_ready  = rst_n && (state_r == S_RUN) && (!d_valid_r || issue_fire_s);
    assign bus.alu_valid = alu_v_s;
    assign bus.bru_valid = bru_v_s;
    assign bus.mau_valid = mau_v_s;
    assign bus.iss_instr = d_instr_r;
    assign bus.iss_pc    = d_pc_r;
    assign bus.iss_rd    = d_rd_r;
    assign bus.iss_rs1   = d_rs1_r;
    assign bus.iss_rs2   = d_rs2_r;
    assign bus.iss_imm   = d_imm_r;
    assign halted        = (state_r == S_HALTED);
    assign issue_count   = issue_count_r;
`ifdef ILLEGAL_TRAP_EN
    assign illegal       = (state_r == S_TRAP);
    assign illegal_pc    = illegal_pc_r;
`else
    assign illegal       = 1'b0;
    assign illegal_pc    = {XLEN{1'b0}};
`endif
endmodule

// File: tb/tb_instr_dispatch.sv
// Directed bench for instr_dispatch: decode vector table plus hazard, stall, halt, illegal and reset sequences.
module tb_instr_dispatch;
    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             halted, illegal;
    logic [XLEN-1:0]  illegal_pc;
    logic [CNT_W-1:0] issue_count;
    logic [2:0]       vl;
    int               checks = 0;
    int               errors = 0;

    instr_dispatch_if #(.XLEN(XLEN)) bus();

    instr_dispatch #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .halted(halted),
        .illegal(illegal), .illegal_pc(illegal_pc), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    assign vl = {bus.alu_valid, bus.bru_valid, bus.mau_valid};

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  vld;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = 32'h0;
        bus.alu_ready = 1'b1; bus.bru_ready = 1'b1; bus.mau_ready = 1'b1;
        bus.wb_valid = 1'b0; bus.wb_rd = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1; bus.in_instr = instr; bus.in_pc = pc;
    endtask

    task automatic wb_pulse(input logic [4:0] rd);
        bus.wb_valid = 1'b1; bus.wb_rd = rd;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    initial begin
        // {instr, {alu,bru,mau}, rd, rs1, rs2, imm}
        vecs[0]  = '{32'h00500093, 3'b100, 5'd1,  5'd0, 5'd0, 32'h00000005};  // addi x1,x0,5
        vecs[1]  = '{32'h00108133, 3'b100, 5'd2,  5'd1, 5'd1, 32'h00000000};  // add x2,x1,x1
        vecs[2]  = '{32'hFE20AE23, 3'b001, 5'd0,  5'd1, 5'd2, 32'hFFFFFFFC};  // sw x2,-4(x1)
        vecs[3]  = '{32'hFE208CE3, 3'b010, 5'd0,  5'd1, 5'd2, 32'hFFFFFFF8};  // beq x1,x2,-8
        vecs[4]  = '{32'h123452B7, 3'b100, 5'd5,  5'd0, 5'd0, 32'h12345000};  // lui x5
        vecs[5]  = '{32'hFFFFF317, 3'b100, 5'd6,  5'd0, 5'd0, 32'hFFFFF000};  // auipc x6
        vecs[6]  = '{32'hFFDFF0EF, 3'b010, 5'd1,  5'd0, 5'd0, 32'hFFFFFFFC};  // jal x1,-4
        vecs[7]  = '{32'h00008067, 3'b010, 5'd0,  5'd1, 5'd0, 32'h00000000};  // jalr x0,0(x1)
        vecs[8]  = '{32'h00812383, 3'b001, 5'd7,  5'd2, 5'd0, 32'h00000008};  // lw x7,8(x2)
        vecs[9]  = '{32'h4030D413, 3'b100, 5'd8,  5'd1, 5'd0, 32'h00000403};  // srai x8,x1,3
        vecs[10] = '{32'h403104B3, 3'b100, 5'd9,  5'd2, 5'd3, 32'h00000000};  // sub x9,x2,x3
        vecs[11] = '{32'hFFF00513, 3'b100, 5'd10, 5'd0, 5'd0, 32'hFFFFFFFF};  // addi x10,x0,-1
        vecs[12] = '{32'h00419863, 3'b010, 5'd0,  5'd3, 5'd4, 32'h00000010};  // bne x3,x4,16

        do_reset();
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_valids", 32'(vl), 32'd0);
        check("rst_count", issue_count, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_iss_instr", bus.iss_instr, 32'd0);

        // Decode table: accept, check the one-cycle-later issue, retire rd by writeback.
        for (int i = 0; i < 13; i++) begin
            present(vecs[i].instr, 32'h1000 + 32'(i * 4));
            #1 check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            tick();
            bus.in_valid = 1'b0;
            #1;
            check($sformatf("v%0d_valid", i), 32'(vl), 32'(vecs[i].vld));
            check($sformatf("v%0d_rd", i), 32'(bus.iss_rd), 32'(vecs[i].rd));
            check($sformatf("v%0d_rs1", i), 32'(bus.iss_rs1), 32'(vecs[i].rs1));
            check($sformatf("v%0d_rs2", i), 32'(bus.iss_rs2), 32'(vecs[i].rs2));
            check($sformatf("v%0d_imm", i), bus.iss_imm, vecs[i].imm);
            check($sformatf("v%0d_pc", i), bus.iss_pc, 32'h1000 + 32'(i * 4));
            tick();
            if (vecs[i].rd != 5'd0) wb_pulse(vecs[i].rd);
        end
        check("table_count", issue_count, 32'd13);

        // RAW stall and same-cycle writeback bypass.
        do_reset();
        present(32'h00500093, 32'h100);
        tick();
        bus.in_valid = 1'b0;
        #1 check("addi_valid", 32'(bus.alu_valid), 32'd1);
        tick();
        present(32'h00108133, 32'h104);
        tick();
        bus.in_valid = 1'b0;
        #1 check("raw_stall", 32'(vl), 32'd0);
        check("raw_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        #1 check("raw_stall2", 32'(vl), 32'd0);
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd1;
        #1 check("bypass_valid", 32'(bus.alu_valid), 32'd1);
        check("bypass_rd", 32'(bus.iss_rd), 32'd2);
        tick();
        bus.wb_valid = 1'b0;
        check("raw_count", issue_count, 32'd2);

        // Stalled store: payload held, store sets no pending bit.
        wb_pulse(5'd2);
        bus.mau_ready = 1'b0;
        present(32'hFE20AE23, 32'h108);
        tick();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("st_hold%0d", c), 32'(vl), 32'b001);
            check($sformatf("st_imm%0d", c), bus.iss_imm, 32'hFFFFFFFC);
            check($sformatf("st_instr%0d", c), bus.iss_instr, 32'hFE20AE23);
            tick();
        end
        bus.mau_ready = 1'b1;
        tick();
        present(32'h000E0293, 32'h10C);   // addi x5,x28,0
        tick();
        bus.in_valid = 1'b0;
        #1 check("st_no_pend", 32'(bus.alu_valid), 32'd1);
        tick();
        present(32'h00700293, 32'h110);   // addi x5,x0,7 -- WAW on x5
        tick();
        bus.in_valid = 1'b0;
        #1 check("waw_stall", 32'(vl), 32'd0);
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd5;
        #1 check("waw_release", 32'(bus.alu_valid), 32'd1);
        tick();
        bus.wb_valid = 1'b0;
        wb_pulse(5'd5);
        check("st_count", issue_count, 32'd5);

        // HALT drain with x3 outstanding.
        present(32'h00100193, 32'h114);
        tick();
        bus.in_valid = 1'b0;
        tick();
        present(32'h00010073, 32'h118);
        tick();
        bus.in_valid = 1'b0;
        #1 check("halt_no_issue", 32'(vl), 32'd0);
        check("halt_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        present(32'h00500093, 32'h11C);
        #1 check("drain_in_ready", 32'(bus.in_ready), 32'd0);
        check("drain_halted", 32'(halted), 32'd0);
        tick();
        #1 check("drain_halted2", 32'(halted), 32'd0);
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd3;
        tick();
        bus.wb_valid = 1'b0;
        #1 check("halted", 32'(halted), 32'd1);
        repeat (3) tick();
        check("halted_no_issue", 32'(vl), 32'd0);
        check("halted_in_ready", 32'(bus.in_ready), 32'd0);
        check("halted_count", issue_count, 32'd6);
        bus.in_valid = 1'b0;

        // Illegal word.
        do_reset();
        check("post_halt_reset", 32'(halted), 32'd0);
        present(32'hFFFFFFFF, 32'h200);
        tick();
        bus.in_valid = 1'b0;
        #1 check("ill_no_issue", 32'(vl), 32'd0);
        tick();
`ifdef ILLEGAL_TRAP_EN
        #1 check("ill_flag", {31'd0, illegal}, 32'd1);
        check("ill_pc", illegal_pc, 32'h200);
        check("ill_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("ill_count", issue_count, 32'd0);
`else
        #1 check("ill_flag", {31'd0, illegal}, 32'd0);
        check("ill_pc", illegal_pc, 32'h0);
        check("ill_in_ready", 32'(bus.in_ready), 32'd1);
        present(32'h00500093, 32'h204);
        tick();
        bus.in_valid = 1'b0;
        #1 check("ill_next_valid", 32'(bus.alu_valid), 32'd1);
        check("ill_next_pc", bus.iss_pc, 32'h204);
        tick();
        check("ill_count", issue_count, 32'd1);
`endif

        // Reset asserted while an instruction is stalled.
        do_reset();
        present(32'h00500093, 32'h300);
        tick();
        bus.in_valid = 1'b0;
        tick();
        present(32'h00108133, 32'h304);
        tick();
        bus.in_valid = 1'b0;
        #1 check("mid_stall", 32'(vl), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mrst_valids", 32'(vl), 32'd0);
        check("mrst_instr", bus.iss_instr, 32'd0);
        check("mrst_rd", 32'(bus.iss_rd), 32'd0);
        check("mrst_count", issue_count, 32'd0);
        check("mrst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("post_mrst_ready", 32'(bus.in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
